sync_fifo_v2: RTL and testbench

Parametrised single-clock FIFO used as the TX/RX data buffer in the UART IP.

---
 rtl/sync_fifo_pkg.sv | 13 +
 rtl/fifo_mem.sv | 26 ++
 rtl/sync_fifo_v2.sv | 133 +++++++++++++
 tb/tb_sync_fifo_v2.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo_v2 buffer and its users.
package sync_fifo_pkg;

  // Read-mode selectors for the FWFT parameter
  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Width needed to hold a fill level in the range 0..depth inclusive
  function automatic int fifo_lvl_wd(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, contents not reset.
module fifo_mem #(
  parameter int DATA_WD = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR_WD = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en_i,
  input  logic [ADDR_WD-1:0] wr_addr_i,
  input  logic [DATA_WD-1:0] wr_data_i,
  input  logic [ADDR_WD-1:0] rd_addr_i,
  output logic [DATA_WD-1:0] rd_data_o
);

  logic [DATA_WD-1:0] mem_q [DEPTH];

  // Store the incoming word at the write address
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with registered or fall-through read, programmable
// almost-full/almost-empty thresholds, flush and sticky error flags.
// Depth may be any value >= 2; pointers wrap by explicit compare.
module sync_fifo_v2
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WD = 8,
  parameter int DEPTH   = 16,
  parameter int FWFT    = FIFO_MODE_REG,
  parameter int LVL_WD  = fifo_lvl_wd(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [DATA_WD-1:0] wr_data,
  input  logic               rd_en,
  output logic [DATA_WD-1:0] rd_data,
  input  logic               flush,
  input  logic [LVL_WD-1:0]  af_thr,
  input  logic [LVL_WD-1:0]  ae_thr,
  input  logic               clr_err,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [LVL_WD-1:0]  level,
  output logic               overflow,
  output logic               underflow
);

  localparam int PTR_WD = $clog2(DEPTH);
  localparam logic [PTR_WD-1:0] PTR_LAST = PTR_WD'(DEPTH - 1);
  localparam logic [LVL_WD-1:0] LVL_FULL = LVL_WD'(DEPTH);

  logic [PTR_WD-1:0]  head_q, head_d;
  logic [PTR_WD-1:0]  tail_q, tail_d;
  logic [LVL_WD-1:0]  level_q, level_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               wr_acc, rd_acc;
  logic [DATA_WD-1:0] mem_rd_data;

  // Flags come straight from the level register, so they describe pre-edge state
  assign full         = (level_q == LVL_FULL);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= af_thr);
  assign almost_empty = (level_q <= ae_thr);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  fifo_mem #(
    .DATA_WD (DATA_WD),
    .DEPTH   (DEPTH),
    .ADDR_WD (PTR_WD)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_acc),
    .wr_addr_i (tail_q),
    .wr_data_i (wr_data),
    .rd_addr_i (head_q),
    .rd_data_o (mem_rd_data)
  );

  // Next pointers, level and sticky errors; flush wins over any access
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    level_d     = level_q;
    overflow_d  = (overflow_q  & ~clr_err) | (wr_en & full  & ~flush);
    underflow_d = (underflow_q & ~clr_err) | (rd_en & empty & ~flush);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
    end else begin
      if (wr_acc) begin
        tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + PTR_WD'(1);
      end
      if (rd_acc) begin
        head_d = (head_q == PTR_LAST) ? '0 : head_q + PTR_WD'(1);
      end
      if (wr_acc && !rd_acc) begin
        level_d = level_q + LVL_WD'(1);
      end else if (rd_acc && !wr_acc) begin
        level_d = level_q - LVL_WD'(1);
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is presented directly; blank while nothing is stored
      assign rd_data = empty ? '0 : mem_rd_data;
    end else begin : g_reg
      logic [DATA_WD-1:0] rd_data_q, rd_data_d;

      assign rd_data_d = rd_acc ? mem_rd_data : rd_data_q;

      // Capture the popped word; hold it otherwise, flush included
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_q <= '0;
        end else begin
          rd_data_q <= rd_data_d;
        end
      end

      assign rd_data = rd_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Directed bench: three instances (DEPTH 8 registered, DEPTH 6 registered,
// DEPTH 4 fall-through) share one stimulus bus; each test checks one of them.
module tb_sync_fifo_v2;
  import sync_fifo_pkg::*;

  localparam int LW8 = fifo_lvl_wd(8);
  localparam int LW6 = fifo_lvl_wd(6);
  localparam int LW4 = fifo_lvl_wd(4);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [7:0] wr_data = '0;

  logic [LW8-1:0] af8 = LW8'(6), ae8 = LW8'(2);
  logic [LW6-1:0] af6 = LW6'(5), ae6 = LW6'(1);
  logic [LW4-1:0] af4 = LW4'(3), ae4 = LW4'(0);

  logic [7:0]     rd8, rd6, rdf;
  logic           full8, empty8, afl8, ael8, ovf8, udf8;
  logic           full6, empty6, afl6, ael6, ovf6, udf6;
  logic           fullf, emptyf, aflf, aelf, ovff, udff;
  logic [LW8-1:0] lvl8;
  logic [LW6-1:0] lvl6;
  logic [LW4-1:0] lvlf;

  int errors = 0;
  int checks = 0;

  sync_fifo_v2 #(.DATA_WD(8), .DEPTH(8), .FWFT(FIFO_MODE_REG)) u_dut8 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd8), .flush(flush), .af_thr(af8), .ae_thr(ae8), .clr_err(clr_err),
    .full(full8), .empty(empty8), .almost_full(afl8), .almost_empty(ael8),
    .level(lvl8), .overflow(ovf8), .underflow(udf8));

  sync_fifo_v2 #(.DATA_WD(8), .DEPTH(6), .FWFT(FIFO_MODE_REG)) u_dut6 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd6), .flush(flush), .af_thr(af6), .ae_thr(ae6), .clr_err(clr_err),
    .full(full6), .empty(empty6), .almost_full(afl6), .almost_empty(ael6),
    .level(lvl6), .overflow(ovf6), .underflow(udf6));

  sync_fifo_v2 #(.DATA_WD(8), .DEPTH(4), .FWFT(FIFO_MODE_FWFT)) u_dutf (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rdf), .flush(flush), .af_thr(af4), .ae_thr(ae4), .clr_err(clr_err),
    .full(fullf), .empty(emptyf), .almost_full(aflf), .almost_empty(aelf),
    .level(lvlf), .overflow(ovff), .underflow(udff));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_level", lvl8, 0);
    chk("rst_empty", empty8, 1);
    chk("rst_full", full8, 0);
    chk("rst_ae", ael8, 1);
    chk("rst_rd", rd8, 0);
    chk("rst_ovf", ovf8, 0);
    chk("rst_udf", udf8, 0);
    chk("rst_fwft_rd", rdf, 0);
    rst = 1'b0;
    step();

    // 1: ordering and overflow on DEPTH 8
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      chk("t1_lvl", lvl8, i);
      chk("t1_af", afl8, (i >= 6) ? 1 : 0);
      chk("t1_full", full8, (i == 8) ? 1 : 0);
    end
    wr_data = 8'h09;
    step();
    chk("t1_ovf_lvl", lvl8, 8);
    chk("t1_ovf", ovf8, 1);
    chk("t1_ovf_full", full8, 1);
    idle();
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      step();
      chk("t1_rd", rd8, i);
      chk("t1_ae", ael8, ((8 - i) <= 2) ? 1 : 0);
    end
    idle();
    step();
    chk("t1_empty", empty8, 1);
    chk("t1_rd_hold", rd8, 8'h08);
    chk("t1_no_udf", udf8, 0);

    // 2: simultaneous read and write at level 4
    do_flush();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      step();
    end
    chk("t2_lvl4", lvl8, 4);
    for (int k = 0; k < 10; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'h14 + k);
      step();
      chk("t2_rw_lvl", lvl8, 4);
      chk("t2_rw_rd", rd8, 8'h10 + k);
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      rd_en = 1'b1;
      step();
      chk("t2_drain", rd8, 8'h1A + k);
    end
    chk("t2_drained", empty8, 1);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h55;
    step();
    chk("t2_e_lvl", lvl8, 1);
    chk("t2_e_udf", udf8, 1);
    chk("t2_e_rd_hold", rd8, 8'h1D);
    idle();
    rd_en = 1'b1;
    step();
    chk("t2_pop55", rd8, 8'h55);
    clr_err = 1'b1; rd_en = 1'b1;
    step();
    chk("t2_setwins_udf", udf8, 1);
    chk("t2_clr_ovf", ovf8, 0);
    rd_en = 1'b0;
    step();
    chk("t2_clr_udf", udf8, 0);
    chk("t2_clr_ovf2", ovf8, 0);
    idle();

    // 3: fall-through mode on DEPTH 4
    do_flush();
    chk("t3_empty_rd", rdf, 0);
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    idle();
    chk("t3_fall", rdf, 8'hA5);
    step();
    chk("t3_hold", rdf, 8'hA5);
    chk("t3_lvl", lvlf, 1);
    rd_en = 1'b1;
    step();
    idle();
    chk("t3_pop_empty", emptyf, 1);
    chk("t3_pop_rd", rdf, 0);
    wr_en = 1'b1; wr_data = 8'hB1;
    step();
    wr_data = 8'hB2;
    step();
    idle();
    chk("t3_b1", rdf, 8'hB1);
    rd_en = 1'b1;
    step();
    idle();
    chk("t3_b2", rdf, 8'hB2);

    // 4: non-power-of-two wrap on DEPTH 6
    do_flush();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h30 + i);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'h33 + k);
      step();
      chk("t4_rd", rd6, 8'h30 + k);
      chk("t4_lvl", lvl6, 3);
    end
    idle();
    for (int i = 4; i <= 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h60 + i);
      step();
      chk("t4_full", full6, (i == 6) ? 1 : 0);
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      rd_en = 1'b1;
      step();
      chk("t4_tail", rd6, 8'h44 + k);
    end
    for (int i = 4; i <= 6; i++) begin
      rd_en = 1'b1;
      step();
      chk("t4_tail2", rd6, 8'h60 + i);
    end
    idle();

    // 5: flush with a concurrent write on DEPTH 8
    do_flush();
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      step();
    end
    idle();
    chk("t5_ovf_set", ovf8, 1);
    for (int k = 0; k < 3; k++) begin
      rd_en = 1'b1;
      step();
    end
    idle();
    chk("t5_lvl5", lvl8, 5);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    step();
    idle();
    chk("t5_lvl0", lvl8, 0);
    chk("t5_empty", empty8, 1);
    chk("t5_ovf_kept", ovf8, 1);
    chk("t5_rd_kept", rd8, 8'h42);
    wr_en = 1'b1; wr_data = 8'h5A;
    step();
    idle();
    rd_en = 1'b1;
    step();
    idle();
    chk("t5_post", rd8, 8'h5A);

    // 6: asynchronous reset during back-to-back writes
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
      step();
    end
    #2 rst = 1'b1;
    #1;
    chk("t6_lvl", lvl8, 0);
    chk("t6_empty", empty8, 1);
    chk("t6_rd", rd8, 0);
    chk("t6_ovf", ovf8, 0);
    chk("t6_udf", udf8, 0);
    rst = 1'b0;
    wr_en = 1'b1; wr_data = 8'h77;
    step();
    idle();
    chk("t6_lvl1", lvl8, 1);
    rd_en = 1'b1;
    step();
    idle();
    chk("t6_rd77", rd8, 8'h77);
    chk("t6_empty2", empty8, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
